// File: rtl/s2p16_deser_if.sv
// Serial-in / parallel-out bus for s2p16_deser; perr exists only when
// S2P16_PARITY_CHK_EN is defined.
interface s2p16_deser_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             sen;
  logic             sdi;
  logic             sfs;
  logic [WIDTH-1:0] dout;
  logic             dvld;
  logic             busy;
  logic             ferr;
`ifdef S2P16_PARITY_CHK_EN
  logic             perr;

  modport master (
    output sen, sdi, sfs,
    input  dout, dvld, busy, ferr, perr
  );
  modport slave (
    input  sen, sdi, sfs,
    output dout, dvld, busy, ferr, perr
  );
`else
  modport master (
    output sen, sdi, sfs,
    input  dout, dvld, busy, ferr
  );
  modport slave (
    input  sen, sdi, sfs,
    output dout, dvld, busy, ferr
  );
`endif
endinterface

// File: rtl/s2p16_deser.sv
// Framed serial-to-parallel deserializer with one-cycle DVLD/FERR strobes.
// Define S2P16_PARITY_CHK_EN to add a trailing even-parity bit check (PAR state, PERR).
module s2p16_deser #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic          i_ck,
  input logic          i_clr,
  s2p16_deser_if.slave io_bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef S2P16_PARITY_CHK_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
  localparam logic [CW-1:0] CNT_PAR = CW'(WIDTH);
`endif

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_dout,  w_dout_nxt;
  logic             r_dvld,  w_dvld_nxt;
  logic             r_ferr,  w_ferr_nxt;
  logic             r_busy;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_shifted;
`ifdef S2P16_PARITY_CHK_EN
  logic             r_perr,  w_perr_nxt;
  logic             w_par_ok;

  assign w_par_ok = ~(^{r_shift, io_bus.sdi});
`endif

  // The first bit enters at the end that walks to DOUT[WIDTH-1] (MSB_FIRST) or DOUT[0].
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_first   = {{(WIDTH-1){1'b0}}, io_bus.sdi};
      assign w_shifted = {r_shift[WIDTH-2:0], io_bus.sdi};
    end else begin : g_lsb
      assign w_first   = {io_bus.sdi, {(WIDTH-1){1'b0}}};
      assign w_shifted = {io_bus.sdi, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_dvld_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef S2P16_PARITY_CHK_EN
    w_perr_nxt  = 1'b0;
`endif
    if (io_bus.sen) begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.sfs) begin
            w_shift_nxt = w_first;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (io_bus.sfs) begin
            w_ferr_nxt  = 1'b1;
            w_shift_nxt = w_first;
            w_cnt_nxt   = CW'(1);
          end else if (r_cnt == CNT_LAST) begin
            w_shift_nxt = w_shifted;
`ifdef S2P16_PARITY_CHK_EN
            w_cnt_nxt   = CNT_PAR;
            w_state_nxt = ST_PAR;
`else
            w_dout_nxt  = w_shifted;
            w_dvld_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
`ifdef S2P16_PARITY_CHK_EN
        ST_PAR: begin
          if (io_bus.sfs) begin
            w_ferr_nxt  = 1'b1;
            w_shift_nxt = w_first;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ST_SHIFT;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            if (w_par_ok) begin
              w_dout_nxt = r_shift;
              w_dvld_nxt = 1'b1;
            end else begin
              w_perr_nxt = 1'b1;
            end
          end
        end
`endif
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_ck or posedge i_clr) begin
    if (i_clr) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_dvld  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef S2P16_PARITY_CHK_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_dvld  <= w_dvld_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
`ifdef S2P16_PARITY_CHK_EN
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign io_bus.dout = r_dout;
  assign io_bus.dvld = r_dvld;
  assign io_bus.busy = r_busy;
  assign io_bus.ferr = r_ferr;
`ifdef S2P16_PARITY_CHK_EN
  assign io_bus.perr = r_perr;
`endif
endmodule

// File: tb/tb_s2p16_deser.sv
// Bench for s2p16_deser: MSB-first and LSB-first instances share one stimulus stream and
// are checked every cycle against a bit-queue reference model.
module tb_s2p16_deser;
  localparam int unsigned W = 16;
`ifdef S2P16_PARITY_CHK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic ck = 1'b0;
  logic clr = 1'b1;
  logic sen = 1'b0;
  logic sfs = 1'b0;
  logic sdi = 1'b0;

  s2p16_deser_if #(.WIDTH(W)) bus_m ();
  s2p16_deser_if #(.WIDTH(W)) bus_l ();

  assign bus_m.sen = sen;
  assign bus_m.sfs = sfs;
  assign bus_m.sdi = sdi;
  assign bus_l.sen = sen;
  assign bus_l.sfs = sfs;
  assign bus_l.sdi = sdi;

  s2p16_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.i_ck(ck), .i_clr(clr), .io_bus(bus_m));
  s2p16_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.i_ck(ck), .i_clr(clr), .io_bus(bus_l));

  always #5 ck = ~ck;

  // Reference model: bits of the current frame in arrival order.
  bit         q[$];
  bit         in_frame;
  logic [W-1:0] exp_m, exp_l;
  logic       exp_dvld, exp_ferr;
`ifdef S2P16_PARITY_CHK_EN
  logic       exp_perr;
`endif
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_dvld = 0;
  int prev_dvld = 0;
  logic       ferr_at_start;
  logic [W-1:0] dout_at_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    exp_m = '0;
    exp_l = '0;
    exp_dvld = 1'b0;
    exp_ferr = 1'b0;
`ifdef S2P16_PARITY_CHK_EN
    exp_perr = 1'b0;
`endif
  endtask

  task automatic complete();
    exp_m = '0;
    exp_l = '0;
    for (int i = 0; i < int'(W); i++) begin
      exp_m[int'(W) - 1 - i] = q[i];
      exp_l[i] = q[i];
    end
    exp_dvld = 1'b1;
    in_frame = 1'b0;
  endtask

  task automatic model_step(input logic s_en, input logic s_fs, input logic s_di);
    exp_dvld = 1'b0;
    exp_ferr = 1'b0;
`ifdef S2P16_PARITY_CHK_EN
    exp_perr = 1'b0;
`endif
    if (!s_en) return;
    if (s_fs) begin
      if (in_frame) exp_ferr = 1'b1;
      q.delete();
      q.push_back(s_di);
      in_frame = 1'b1;
    end else if (in_frame) begin
`ifdef S2P16_PARITY_CHK_EN
      if (q.size() == int'(W)) begin
        int ones = int'(s_di);
        foreach (q[i]) ones += int'(q[i]);
        if (ones % 2 == 0) complete();
        else begin
          exp_perr = 1'b1;
          in_frame = 1'b0;
        end
        return;
      end
`endif
      q.push_back(s_di);
`ifndef S2P16_PARITY_CHK_EN
      if (q.size() == int'(W)) complete();
`endif
    end
  endtask

  task automatic check_all();
    chk("dout_msb", 32'(bus_m.dout), 32'(exp_m));
    chk("dout_lsb", 32'(bus_l.dout), 32'(exp_l));
    chk("dvld_msb", 32'(bus_m.dvld), 32'(exp_dvld));
    chk("dvld_lsb", 32'(bus_l.dvld), 32'(exp_dvld));
    chk("busy", 32'(bus_m.busy), 32'(in_frame));
    chk("ferr", 32'(bus_m.ferr), 32'(exp_ferr));
`ifdef S2P16_PARITY_CHK_EN
    chk("perr", 32'(bus_m.perr), 32'(exp_perr));
`endif
  endtask

  task automatic step(input logic s_en, input logic s_fs, input logic s_di);
    sen = s_en;
    sfs = s_fs;
    sdi = s_di;
    @(posedge ck);
    #1;
    cyc++;
    model_step(s_en, s_fs, s_di);
    if (bus_m.dvld) begin
      prev_dvld = last_dvld;
      last_dvld = cyc;
    end
    check_all();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < int'(W); i++) begin
      repeat (gap) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, i == 0, w[int'(W) - 1 - i]);
      if (i == 0) begin
        ferr_at_start = bus_m.ferr;
        dout_at_start = bus_m.dout;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    send_bits(w, gap);
`ifdef S2P16_PARITY_CHK_EN
    repeat (gap) step(1'b0, 1'($urandom), 1'($urandom));
    step(1'b1, 1'b0, ^w);
`endif
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge ck);
    #1;
    check_all();
    chk("rst_dout", 32'(bus_m.dout), 32'h0);
    chk("rst_busy", 32'(bus_m.busy), 32'h0);
    clr = 1'b0;

    // Directed frame, no gaps.
    send_word(16'hA5C3, 0);
    chk("a5c3_dvld", 32'(bus_m.dvld), 32'h1);
    chk("a5c3_msb", 32'(bus_m.dout), 32'hA5C3);
    chk("a5c3_lsb", 32'(bus_l.dout), 32'hC3A5);
    chk("a5c3_busy", 32'(bus_m.busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("dvld_single", 32'(bus_m.dvld), 32'h0);

    // Back-to-back: second SFS lands in the DVLD cycle of the first word.
    send_word(16'h1234, 0);
    chk("b2b_first", 32'(bus_m.dout), 32'h1234);
    send_word(16'hFFFF, 0);
    chk("b2b_second", 32'(bus_m.dout), 32'hFFFF);
    chk("b2b_spacing", 32'(last_dvld - prev_dvld), 32'(int'(W) + PAR_BITS));

    // SEN high every third cycle, SDI/SFS toggling while disabled.
    send_word(16'hA5C3, 2);
    chk("gap_msb", 32'(bus_m.dout), 32'hA5C3);
    chk("gap_lsb", 32'(bus_l.dout), 32'hC3A5);

    // Resync at bit 9 of a frame.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'($urandom));
    send_word(16'h00FF, 0);
    chk("ferr_pulse", 32'(ferr_at_start), 32'h1);
    chk("ferr_hold", 32'(dout_at_start), 32'hA5C3);
    chk("ferr_resync", 32'(bus_m.dout), 32'h00FF);

    // Asynchronous clear mid-frame.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom));
    clr = 1'b1;
    #2;
    chk("clr_dout", 32'(bus_m.dout), 32'h0);
    chk("clr_busy", 32'(bus_m.busy), 32'h0);
    chk("clr_dvld", 32'(bus_m.dvld), 32'h0);
    model_reset();
    @(posedge ck);
    #1;
    clr = 1'b0;
    check_all();
    send_word(16'h5A3C, 0);
    chk("post_clr", 32'(bus_m.dout), 32'h5A3C);

`ifdef S2P16_PARITY_CHK_EN
    send_bits(16'h0001, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("par_ok_dvld", 32'(bus_m.dvld), 32'h1);
    chk("par_ok_dout", 32'(bus_m.dout), 32'h0001);
    send_bits(16'h00F0, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("par_bad_perr", 32'(bus_m.perr), 32'h1);
    chk("par_bad_dvld", 32'(bus_m.dvld), 32'h0);
    chk("par_bad_dout", 32'(bus_m.dout), 32'h0001);
`endif

    // Random traffic: occasional SFS gives a mix of full frames and resyncs.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
